// File: rtl/cpu_reg_bank.sv
// CPU register bank: NREG general registers, PC and SP with two prioritised write
// ports, relative-branch PC arithmetic, sticky stack-wrap flags and a one-level shadow context.
module cpu_reg_bank #(
   parameter int              DW       = 8,
   parameter int              PCW      = 16,
   parameter int              NREG     = 4,
   parameter int              AW       = 2,
   parameter logic [DW-1:0]   SP_RESET = 8'hFF,
   parameter logic [PCW-1:0]  PC_RESET = 16'h0,
   parameter bit              SHADOW   = 1'b1
) (
   input  logic            clk,
   input  logic            rst_x,
   input  logic            hp_we,
   input  logic [AW-1:0]   hp_waddr,
   input  logic [DW-1:0]   hp_wdata,
   input  logic            lp_we,
   input  logic [AW-1:0]   lp_waddr,
   input  logic [DW-1:0]   lp_wdata,
   input  logic [AW-1:0]   rd0_addr,
   output logic [DW-1:0]   rd0_data,
   input  logic [AW-1:0]   rd1_addr,
   output logic [DW-1:0]   rd1_data,
   input  logic            pc_load,
   input  logic [PCW-1:0]  pc_load_val,
   input  logic            pc_add,
   input  logic [DW-1:0]   pc_offset,
   input  logic            pc_inc,
   output logic [PCW-1:0]  pc,
   input  logic            sp_load,
   input  logic [DW-1:0]   sp_load_val,
   input  logic            sp_push,
   input  logic            sp_pull,
   output logic [DW-1:0]   sp,
   output logic            stk_ovf,
   output logic            stk_unf,
   input  logic            stk_err_clr,
   input  logic            ctx_save,
   input  logic            ctx_restore,
   output logic            ctx_valid,
   output logic            wr_conflict
);

   logic [DW-1:0]  gpr_q    [NREG];
   logic [DW-1:0]  gpr_d    [NREG];
   logic [DW-1:0]  sh_gpr_q [NREG];
   logic [DW-1:0]  sh_gpr_d [NREG];
   logic [PCW-1:0] pc_q, pc_d, sh_pc_q, sh_pc_d;
   logic [DW-1:0]  sp_q, sp_d, sh_sp_q, sh_sp_d;
   logic           stk_ovf_q, stk_ovf_d, stk_unf_q, stk_unf_d;
   logic           ctx_valid_q, ctx_valid_d, wr_conflict_q, wr_conflict_d;
   logic           ovf_set, unf_set;
   logic           restore_act, save_act;

   // A save issued together with a restore is always ignored, valid or not.
   assign restore_act = SHADOW && ctx_restore && ctx_valid_q;
   assign save_act    = SHADOW && ctx_save && !ctx_restore;

   // Unimplemented addresses read as zero.
   always_comb begin
      rd0_data = '0;
      rd1_data = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rd0_addr == AW'(i)) rd0_data = gpr_q[i];
         if (rd1_addr == AW'(i)) rd1_data = gpr_q[i];
      end
   end

   always_comb begin
      gpr_d    = gpr_q;
      sh_gpr_d = sh_gpr_q;
      pc_d     = pc_q;
      sh_pc_d  = sh_pc_q;
      sp_d     = sp_q;
      sh_sp_d  = sh_sp_q;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      if (restore_act) begin
         gpr_d = sh_gpr_q;
         pc_d  = sh_pc_q;
         sp_d  = sh_sp_q;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (hp_we && hp_waddr == AW'(i))
               gpr_d[i] = hp_wdata;
            else if (lp_we && lp_waddr == AW'(i))
               gpr_d[i] = lp_wdata;
         end
         if (pc_load)
            pc_d = pc_load_val;
         else if (pc_add)
            pc_d = pc_q + PCW'(signed'(pc_offset));
         else if (pc_inc)
            pc_d = pc_q + PCW'(1);
         // Simultaneous push and pull cancel out and never flag a wrap.
         if (sp_load) begin
            sp_d = sp_load_val;
         end else if (sp_push && !sp_pull) begin
            sp_d    = sp_q - DW'(1);
            ovf_set = (sp_q == '0);
         end else if (sp_pull && !sp_push) begin
            sp_d    = sp_q + DW'(1);
            unf_set = (sp_q == '1);
         end
         if (save_act) begin
            sh_gpr_d = gpr_q;
            sh_pc_d  = pc_q;
            sh_sp_d  = sp_q;
         end
      end
      ctx_valid_d = ctx_valid_q;
      if (ctx_restore)
         ctx_valid_d = 1'b0;
      else if (save_act)
         ctx_valid_d = 1'b1;
      stk_ovf_d     = ovf_set | (stk_ovf_q & ~stk_err_clr);
      stk_unf_d     = unf_set | (stk_unf_q & ~stk_err_clr);
      wr_conflict_d = hp_we && lp_we && (hp_waddr == lp_waddr);
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_q[i]    <= '0;
            sh_gpr_q[i] <= '0;
         end
         pc_q          <= PC_RESET;
         sh_pc_q       <= '0;
         sp_q          <= SP_RESET;
         sh_sp_q       <= '0;
         stk_ovf_q     <= 1'b0;
         stk_unf_q     <= 1'b0;
         ctx_valid_q   <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         gpr_q         <= gpr_d;
         sh_gpr_q      <= sh_gpr_d;
         pc_q          <= pc_d;
         sh_pc_q       <= sh_pc_d;
         sp_q          <= sp_d;
         sh_sp_q       <= sh_sp_d;
         stk_ovf_q     <= stk_ovf_d;
         stk_unf_q     <= stk_unf_d;
         ctx_valid_q   <= ctx_valid_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign pc          = pc_q;
   assign sp          = sp_q;
   assign stk_ovf     = stk_ovf_q;
   assign stk_unf     = stk_unf_q;
   assign ctx_valid   = ctx_valid_q;
   assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Bench for cpu_reg_bank: directed scenarios plus randomized traffic checked against
// an array-based reference model; a second NREG=3, SHADOW=0 instance covers the variants.
module tb_cpu_reg_bank;

   logic clk = 1'b0;
   logic rst_x;
   always #5 clk = ~clk;

   logic        hp_we, lp_we, pc_load, pc_add, pc_inc, sp_load, sp_push, sp_pull;
   logic        stk_err_clr, ctx_save, ctx_restore;
   logic [1:0]  hp_waddr, lp_waddr, rd0_addr, rd1_addr;
   logic [7:0]  hp_wdata, lp_wdata, pc_offset, sp_load_val;
   logic [15:0] pc_load_val;

   logic [7:0]  rd0_data, rd1_data, sp;
   logic [15:0] pc;
   logic        stk_ovf, stk_unf, ctx_valid, wr_conflict;
   logic [7:0]  rd0_data2, rd1_data2, sp2;
   logic [15:0] pc2;
   logic        stk_ovf2, stk_unf2, ctx_valid2, wr_conflict2;

   cpu_reg_bank dut (
      .clk(clk), .rst_x(rst_x),
      .hp_we(hp_we), .hp_waddr(hp_waddr), .hp_wdata(hp_wdata),
      .lp_we(lp_we), .lp_waddr(lp_waddr), .lp_wdata(lp_wdata),
      .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
      .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_add(pc_add), .pc_offset(pc_offset),
      .pc_inc(pc_inc), .pc(pc),
      .sp_load(sp_load), .sp_load_val(sp_load_val), .sp_push(sp_push), .sp_pull(sp_pull), .sp(sp),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf), .stk_err_clr(stk_err_clr),
      .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(ctx_valid),
      .wr_conflict(wr_conflict)
   );

   cpu_reg_bank #(.NREG(3), .SHADOW(1'b0)) dut2 (
      .clk(clk), .rst_x(rst_x),
      .hp_we(hp_we), .hp_waddr(hp_waddr), .hp_wdata(hp_wdata),
      .lp_we(lp_we), .lp_waddr(lp_waddr), .lp_wdata(lp_wdata),
      .rd0_addr(rd0_addr), .rd0_data(rd0_data2), .rd1_addr(rd1_addr), .rd1_data(rd1_data2),
      .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_add(pc_add), .pc_offset(pc_offset),
      .pc_inc(pc_inc), .pc(pc2),
      .sp_load(sp_load), .sp_load_val(sp_load_val), .sp_push(sp_push), .sp_pull(sp_pull), .sp(sp2),
      .stk_ovf(stk_ovf2), .stk_unf(stk_unf2), .stk_err_clr(stk_err_clr),
      .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(ctx_valid2),
      .wr_conflict(wr_conflict2)
   );

   int checkCount = 0;
   int failCount  = 0;

   int mGpr[4];
   int mShGpr[4];
   int mPc, mSp, mShPc, mShSp;
   bit mOvf, mUnf, mValid, mConflict;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) begin
         mGpr[i]   = 0;
         mShGpr[i] = 0;
      end
      mPc = 0; mSp = 255; mShPc = 0; mShSp = 0;
      mOvf = 0; mUnf = 0; mValid = 0; mConflict = 0;
   endtask

   // One clock of the architectural rules, evaluated from the values present at the edge.
   task automatic modelStep();
      int ng[4];
      int npc, nsp;
      bit setO, setU;
      ng = mGpr; npc = mPc; nsp = mSp; setO = 0; setU = 0;
      mConflict = hp_we && lp_we && (hp_waddr == lp_waddr);
      if (ctx_restore && mValid) begin
         ng = mShGpr; npc = mShPc; nsp = mShSp;
      end else begin
         if (lp_we) ng[lp_waddr] = lp_wdata;
         if (hp_we) ng[hp_waddr] = hp_wdata;
         if (pc_load)     npc = pc_load_val;
         else if (pc_add) npc = (mPc + 65536 + int'($signed(pc_offset))) % 65536;
         else if (pc_inc) npc = (mPc + 1) % 65536;
         if (sp_load) nsp = sp_load_val;
         else if (sp_push && !sp_pull) begin setO = (mSp == 0);   nsp = (mSp + 255) % 256; end
         else if (sp_pull && !sp_push) begin setU = (mSp == 255); nsp = (mSp + 1) % 256; end
         if (ctx_save && !ctx_restore) begin
            mShGpr = mGpr; mShPc = mPc; mShSp = mSp;
         end
      end
      if (ctx_restore)   mValid = 0;
      else if (ctx_save) mValid = 1;
      mOvf = setO ? 1'b1 : (stk_err_clr ? 1'b0 : mOvf);
      mUnf = setU ? 1'b1 : (stk_err_clr ? 1'b0 : mUnf);
      mGpr = ng; mPc = npc; mSp = nsp;
   endtask

   task automatic clearInputs();
      hp_we = 0; hp_waddr = 0; hp_wdata = 0; lp_we = 0; lp_waddr = 0; lp_wdata = 0;
      pc_load = 0; pc_load_val = 0; pc_add = 0; pc_offset = 0; pc_inc = 0;
      sp_load = 0; sp_load_val = 0; sp_push = 0; sp_pull = 0;
      stk_err_clr = 0; ctx_save = 0; ctx_restore = 0;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkModel();
      checkOutput("rd0", 32'(rd0_data), 32'(mGpr[rd0_addr]));
      checkOutput("rd1", 32'(rd1_data), 32'(mGpr[rd1_addr]));
      checkOutput("pc", 32'(pc), 32'(mPc));
      checkOutput("sp", 32'(sp), 32'(mSp));
      checkOutput("stk_ovf", 32'(stk_ovf), 32'(mOvf));
      checkOutput("stk_unf", 32'(stk_unf), 32'(mUnf));
      checkOutput("ctx_valid", 32'(ctx_valid), 32'(mValid));
      checkOutput("wr_conflict", 32'(wr_conflict), 32'(mConflict));
      checkOutput("ctx_valid_noshadow", 32'(ctx_valid2), 32'(0));
      if (rd1_addr == 2'd3) checkOutput("rd_oor_noshadow", 32'(rd1_data2), 32'(0));
   endtask

   task automatic checkResetState(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd0_addr = 2'(i);
         #0;
         checkOutput({tag, "_gpr"}, 32'(rd0_data), 32'(0));
      end
      checkOutput({tag, "_pc"}, 32'(pc), 32'h0000);
      checkOutput({tag, "_sp"}, 32'(sp), 32'hFF);
      checkOutput({tag, "_ovf"}, 32'(stk_ovf), 32'(0));
      checkOutput({tag, "_unf"}, 32'(stk_unf), 32'(0));
      checkOutput({tag, "_ctx_valid"}, 32'(ctx_valid), 32'(0));
      checkOutput({tag, "_conflict"}, 32'(wr_conflict), 32'(0));
   endtask

   initial begin
      logic [7:0] spPick [5];
      rst_x = 1'b0;
      clearInputs();
      rd0_addr = 0; rd1_addr = 0;
      modelReset();
      #12;
      checkResetState("reset_init");
      rst_x = 1'b1;

      // Same-address and different-address write port behaviour
      hp_we = 1; hp_waddr = 1; hp_wdata = 8'h11; lp_we = 1; lp_waddr = 1; lp_wdata = 8'h22;
      applyStimulus();
      clearInputs();
      rd0_addr = 1; #1;
      checkOutput("same_addr_hp_wins", 32'(rd0_data), 32'h11);
      checkOutput("conflict_pulse", 32'(wr_conflict), 32'(1));
      hp_we = 1; hp_waddr = 0; hp_wdata = 8'hAA; lp_we = 1; lp_waddr = 2; lp_wdata = 8'hBB;
      applyStimulus();
      clearInputs();
      rd0_addr = 0; rd1_addr = 2; #1;
      checkOutput("diff_addr_hp", 32'(rd0_data), 32'hAA);
      checkOutput("diff_addr_lp", 32'(rd1_data), 32'hBB);
      checkOutput("no_conflict", 32'(wr_conflict), 32'(0));

      // PC wrap, negative branch and request priority
      pc_load = 1; pc_load_val = 16'hFFFF; applyStimulus(); clearInputs();
      pc_inc = 1; applyStimulus(); clearInputs();
      checkOutput("pc_wrap", 32'(pc), 32'h0000);
      pc_load = 1; pc_load_val = 16'h0005; applyStimulus(); clearInputs();
      pc_add = 1; pc_offset = 8'hF0; pc_inc = 1; applyStimulus(); clearInputs();
      checkOutput("pc_add_neg", 32'(pc), 32'hFFF5);
      pc_load = 1; pc_load_val = 16'h1234; pc_add = 1; pc_offset = 8'h05; pc_inc = 1;
      applyStimulus(); clearInputs();
      checkOutput("pc_priority", 32'(pc), 32'h1234);

      // Stack wraps and sticky flags
      sp_load = 1; sp_load_val = 8'h00; applyStimulus(); clearInputs();
      sp_push = 1; applyStimulus(); clearInputs();
      checkOutput("push_wrap_sp", 32'(sp), 32'hFF);
      checkOutput("push_wrap_ovf", 32'(stk_ovf), 32'(1));
      sp_pull = 1; applyStimulus(); clearInputs();
      checkOutput("pull_wrap_sp", 32'(sp), 32'h00);
      checkOutput("pull_wrap_unf", 32'(stk_unf), 32'(1));
      sp_push = 1; sp_pull = 1; applyStimulus(); clearInputs();
      checkOutput("push_pull_sp", 32'(sp), 32'h00);
      sp_push = 1; stk_err_clr = 1; applyStimulus(); clearInputs();
      checkOutput("set_beats_clr_ovf", 32'(stk_ovf), 32'(1));
      checkOutput("clr_unf", 32'(stk_unf), 32'(0));
      stk_err_clr = 1; applyStimulus(); clearInputs();
      checkOutput("clr_ovf", 32'(stk_ovf), 32'(0));

      // Shadow context save / modify / restore
      lp_we = 1; lp_waddr = 0; lp_wdata = 8'h05;
      pc_load = 1; pc_load_val = 16'h0200; sp_load = 1; sp_load_val = 8'hFD;
      applyStimulus(); clearInputs();
      ctx_save = 1; applyStimulus(); clearInputs();
      checkOutput("save_valid", 32'(ctx_valid), 32'(1));
      checkOutput("save_valid_noshadow", 32'(ctx_valid2), 32'(0));
      lp_we = 1; lp_waddr = 0; lp_wdata = 8'h99;
      pc_load = 1; pc_load_val = 16'h1111; sp_load = 1; sp_load_val = 8'h10;
      applyStimulus(); clearInputs();
      ctx_restore = 1; lp_we = 1; lp_waddr = 0; lp_wdata = 8'h77; pc_inc = 1; sp_push = 1;
      applyStimulus(); clearInputs();
      rd0_addr = 0; #1;
      checkOutput("restore_a", 32'(rd0_data), 32'h05);
      checkOutput("restore_pc", 32'(pc), 32'h0200);
      checkOutput("restore_sp", 32'(sp), 32'hFD);
      checkOutput("restore_valid", 32'(ctx_valid), 32'(0));
      ctx_restore = 1; pc_inc = 1; applyStimulus(); clearInputs();
      checkOutput("restore_invalid_pc", 32'(pc), 32'h0201);
      checkOutput("restore_invalid_a", 32'(rd0_data), 32'h05);

      // Out-of-range register on the NREG=3 instance
      hp_we = 1; hp_waddr = 3; hp_wdata = 8'h5A; applyStimulus(); clearInputs();
      rd1_addr = 3; #1;
      checkOutput("oor_read_zero", 32'(rd1_data2), 32'(0));

      // Randomized traffic against the reference model
      spPick[0] = 8'h00; spPick[1] = 8'h01; spPick[2] = 8'hFE; spPick[3] = 8'hFF;
      for (int n = 0; n < 600; n++) begin
         spPick[4]   = 8'($urandom);
         hp_we       = ($urandom_range(0, 3) == 0);
         hp_waddr    = 2'($urandom);
         hp_wdata    = 8'($urandom);
         lp_we       = ($urandom_range(0, 1) == 0);
         lp_waddr    = 2'($urandom);
         lp_wdata    = 8'($urandom);
         rd0_addr    = 2'($urandom);
         rd1_addr    = 2'($urandom);
         pc_load     = ($urandom_range(0, 7) == 0);
         pc_load_val = 16'($urandom);
         pc_add      = ($urandom_range(0, 3) == 0);
         pc_offset   = 8'($urandom);
         pc_inc      = ($urandom_range(0, 1) == 0);
         sp_load     = ($urandom_range(0, 9) == 0);
         sp_load_val = spPick[$urandom_range(0, 4)];
         sp_push     = ($urandom_range(0, 2) == 0);
         sp_pull     = ($urandom_range(0, 2) == 0);
         stk_err_clr = ($urandom_range(0, 9) == 0);
         ctx_save    = ($urandom_range(0, 9) == 0);
         ctx_restore = ($urandom_range(0, 9) == 0);
         applyStimulus();
         checkModel();
      end
      clearInputs();

      // Asynchronous reset in the middle of a cycle with live state
      sp_load = 1; sp_load_val = 8'h00; hp_we = 1; hp_waddr = 2; hp_wdata = 8'h3C;
      applyStimulus(); clearInputs();
      sp_push = 1; ctx_save = 1; applyStimulus(); clearInputs();
      checkOutput("pre_reset_ovf", 32'(stk_ovf), 32'(1));
      checkOutput("pre_reset_valid", 32'(ctx_valid), 32'(1));
      #2 rst_x = 1'b0;
      #1;
      checkResetState("reset_async");
      modelReset();
      #1 rst_x = 1'b1;
      rd0_addr = 2; rd1_addr = 0;
      applyStimulus();
      checkModel();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
